// File: rtl/spi_target.sv
// spi_target: SPI target port with one-byte RX/TX buffers, all four CPOL/CPHA
// modes, and an 8-register CPU interface.
module spi_target (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_clk,
    input  logic       mosi,
    input  logic       cs_n,
    output logic       miso,
    output logic       miso_oe,
    output logic       interrupt,
    input  logic [2:0] reg_addr,
    input  logic [7:0] reg_data_in,
    output logic [7:0] reg_data_out,
    input  logic       reg_read,
    input  logic       reg_write
);
    logic [1:0] sck_sy, mosi_sy, cs_sy, mode;
    logic       sck_d, cs_d, cs_active, load_pend, rx_valid, tx_full, overrun, underrun;
    logic [5:0] ctrl;
    logic [2:0] bit_cnt, int_status;
    logic [6:0] r_in, sh;
    logic [7:0] rx_data, tx_hold, rx_byte, load_val;
    logic       en, sck_edge, lead, sample, shift, cs_fall, cs_rise, start, abort, act;
    logic       rx_done, rx_store, load, wr0, wr1, wr3, rd0;

    assign en       = ctrl[2];
    assign wr0      = reg_write && reg_addr == 3'd0;
    assign wr1      = reg_write && reg_addr == 3'd1;
    assign wr3      = reg_write && reg_addr == 3'd3;
    assign rd0      = reg_read && reg_addr == 3'd0;
    assign sck_edge = sck_sy[1] ^ sck_d;
    // leading edge: SCK moves away from the latched idle level
    assign lead     = sck_edge & (sck_sy[1] ^ mode[1]);
    assign sample   = mode[0] ? sck_edge & ~lead : lead;
    assign shift    = mode[0] ? lead : sck_edge & ~lead;
    assign cs_fall  = cs_d & ~cs_sy[1];
    assign cs_rise  = ~cs_d & cs_sy[1];
    assign start    = cs_fall & en;
    assign abort    = cs_active & (cs_rise | ~en);
    assign act      = cs_active & ~abort;
    assign rx_byte  = {r_in, mosi_sy[1]};
    assign rx_done  = act & sample & (bit_cnt == 3'd7);
    // a same-cycle rx_data read frees the buffer for the incoming byte
    assign rx_store = rx_done & (~rx_valid | rd0);
    assign load     = (start & ~ctrl[0]) | (act & shift & load_pend);
    assign load_val = tx_full ? tx_hold : 8'hFF;
    assign miso_oe  = cs_active & en;
    assign interrupt = |(int_status & ctrl[5:3]);
    assign reg_data_out = reg_addr == 3'd0 ? rx_data :
                          reg_addr == 3'd1 ? {3'b0, overrun, underrun, cs_active, ~tx_full, rx_valid} :
                          reg_addr == 3'd2 ? {2'b0, ctrl} :
                          reg_addr == 3'd3 ? {5'b0, int_status} : 8'h00;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sck_sy     <= 2'b00;
            mosi_sy    <= 2'b00;
            cs_sy      <= 2'b11;
            sck_d      <= 1'b0;
            cs_d       <= 1'b1;
            ctrl       <= 6'd0;
            mode       <= 2'd0;
            cs_active  <= 1'b0;
            load_pend  <= 1'b0;
            bit_cnt    <= 3'd0;
            r_in       <= 7'd0;
            sh         <= 7'h7F;
            miso       <= 1'b1;
            rx_data    <= 8'd0;
            rx_valid   <= 1'b0;
            tx_hold    <= 8'd0;
            tx_full    <= 1'b0;
            overrun    <= 1'b0;
            underrun   <= 1'b0;
            int_status <= 3'd0;
        end else begin
            sck_sy     <= {sck_sy[0], spi_clk};
            mosi_sy    <= {mosi_sy[0], mosi};
            cs_sy      <= {cs_sy[0], cs_n};
            sck_d      <= sck_sy[1];
            cs_d       <= cs_sy[1];
            if (reg_write && reg_addr == 3'd2) ctrl <= reg_data_in[5:0];
            if (wr0) tx_hold <= reg_data_in;
            if (rx_store) rx_data <= rx_byte;
            tx_full    <= wr0 | (tx_full & ~load);
            rx_valid   <= rx_store | (rx_valid & ~rd0);
            overrun    <= (rx_done & ~rx_store) | (overrun & ~(wr1 & reg_data_in[4]));
            underrun   <= (load & ~tx_full) | (underrun & ~(wr1 & reg_data_in[3]));
            int_status <= {abort & cs_rise, load & tx_full, rx_store} | (int_status & ~(wr3 ? reg_data_in[2:0] : 3'b0));
            if (abort) begin
                cs_active <= 1'b0;
                bit_cnt   <= 3'd0;
                miso      <= 1'b1;
            end else begin
                if (start) begin
                    cs_active <= 1'b1;
                    bit_cnt   <= 3'd0;
                    mode      <= ctrl[1:0];
                    load_pend <= ctrl[0];
                end
                if (load) begin
                    sh   <= load_val[6:0];
                    miso <= load_val[7];
                end else if (act & shift) begin
                    sh   <= {sh[5:0], 1'b1};
                    miso <= sh[6];
                end
                if (act & sample) begin
                    r_in    <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (rx_done) load_pend <= 1'b1;
                else if (load) load_pend <= 1'b0;
            end
        end
    end
endmodule

// File: doc/spi_target.md
# spi_target

SPI target (slave) port: the responder for the codebase's `spi` initiator. It attaches to an external SPI master, shifts bytes in on MOSI and out on MISO in any of the four CPOL/CPHA modes, and buffers one byte in each direction. It raises an interrupt on byte receipt, TX buffer drain and CS release. The CPU sees it as one 8-register slot on the same `reg_*` bus used by the other peripherals.

## Interface
- No parameters.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-low reset: low at a `clk` edge resets the block.
- `spi_clk`  in  1  SCK from the external master; asynchronous to `clk`.
- `mosi`  in  1  data from the master; asynchronous.
- `cs_n`  in  1  target select, active low; asynchronous.
- `miso`  out  1  data to the master.
- `miso_oe`  out  1  MISO output enable, for an external tristate.
- `interrupt`  out  1  level interrupt: OR of (int_status & int_enable).
- `reg_addr`  in  3  register index.
- `reg_data_in`  in  8  write data.
- `reg_data_out`  out  8  read data, combinational from `reg_addr`.
- `reg_read`  in  1  single-cycle read strobe; used for side effects only.
- `reg_write`  in  1  single-cycle write strobe.

## Operation
- Registers:
  - 0 R: rx_data; the read clears rx_valid.
  - 0 W: tx_hold; the write sets tx_full.
  - 1 R: status = {3'b0, overrun, underrun, cs_active, ~tx_full, rx_valid}.
  - 1 W: writing 1 to bit 3 clears underrun; writing 1 to bit 4 clears overrun.
  - 2 RW: ctrl. [1:0] is mode = {CPOL, CPHA}; [2] enable; [5:3] int_enable = {cs, tx, rx}.
  - 3 R: int_status = {5'b0, cs, tx, rx}.
  - 3 W: write-1-to-clear on int_status.
  - 4–7: read 0, writes ignored.
- Input synchronisers: `spi_clk`, `mosi` and `cs_n` each pass through 2 flops. All edge detection uses the synchronised values.
- Transfer start: a synchronised `cs_n` falling edge while enable=1 does the following.
  - Latches mode into the active mode; ctrl writes during a transfer take effect at the next CS fall.
  - Clears the bit counter and sets cs_active.
- Edge roles:
  - Leading edge = SCK leaving its CPOL idle level; trailing edge = the opposite transition.
  - CPHA=0: sample on leading edges, shift on trailing edges.
  - CPHA=1: shift on leading edges, sample on trailing edges.
- Bit order: MSB first in both directions.
- Sample: shift the synchronised `mosi` into r_in and increment the bit counter. On the 8th sample of a byte:
  - If rx_valid=0: rx_data <= byte, rx_valid=1, int_status.rx=1.
  - If rx_valid=1: the new byte is discarded and overrun=1.
  - The bit counter wraps to 0.
- TX load at byte boundary. Load points:
  - CPHA=0: the CS fall for the first byte; the first shift edge of each later byte (the trailing edge after the previous 8th sample).
  - CPHA=1: the first shift edge of every byte.
- At a load:
  - If tx_full=1: shift register <= tx_hold, tx_full=0, int_status.tx=1.
  - If tx_full=0: shift register <= 8'hFF and underrun=1.
  - `miso` presents bit 7.
- Every other shift edge: `miso` presents the next bit.
- Abort: `cs_n` rising, or enable cleared, while cs_active.
  - Partial RX byte discarded and bit counter cleared; cs_active=0.
  - `miso_oe`=0 and `miso`=1.
  - int_status.cs=1, except when the abort is caused by enable being cleared.
  - tx_hold and tx_full are unchanged.
- `miso_oe` = cs_active & enable.
- Same-cycle conflicts:
  - Reg-0 read in the same cycle as an RX completion: the new byte is stored, rx_valid stays 1, no overrun.
  - Reg-0 write in the same cycle as a TX load with tx_full=0: underrun, 8'hFF is sent, and the written byte stays in tx_hold with tx_full=1.
  - Reg-0 write while tx_full=1: overwrites tx_hold, no error.
  - Hardware set and W1C of the same int_status bit in one cycle: the set wins.
- Reset values: rx_data=0, tx_hold=0, all flags 0, ctrl=0 (disabled, mode 0), bit counter 0, cs_active=0, `miso`=1, `miso_oe`=0, `interrupt`=0.

## Timing
- `miso` changes 3 `clk` cycles after the shifting SCK edge (or the CS fall) at the pins: 2 synchroniser cycles plus 1 register.
- RX flags and int_status update 3 cycles after the sampling edge at the pin; `interrupt` follows 1 cycle later at most.
- The SCK high and low times must each be ≥ 4 `clk` periods, and CS setup to the first SCK edge must be ≥ 4 `clk` periods. Behaviour is undefined below these limits.
- Register writes take effect at the `clk` edge where the strobe is sampled. Reads are combinational; read side effects apply at that same edge.

## Test plan
- Mode 0, tx_hold=8'hA5 written before CS: master sends 8'h3C. Master receives 8'hA5; rx_data=8'h3C; status reads 0x03; `interrupt` rises with int_enable=3'b011.
- Modes 1/2/3, two back-to-back bytes with tx_hold refilled after each tx interrupt: send 8'h81 then 8'h7E, return 8'hC3 then 8'h18. Bit-exact in both directions.
- No tx_hold write before a transfer: master reads 8'hFF and underrun=1. Write 1 to status bit 3 → underrun=0.
- Two received bytes without reading rx_data: rx_data holds the first byte and overrun=1. A reg-0 read clears rx_valid.
- CS raised after 5 bits: rx_valid stays 0, int_status.cs=1, `miso_oe`=0. The next full byte is received correctly.
- `reset` driven low mid-byte: all outputs at their reset values on the next `clk` edge; ctrl reads 0.
